// File: rtl/ttt2_link_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : ttt2_link_pkg
// Description : Shared definitions for the ttt2 two-phase dual-rail link.
//               - tx_state_t     : transmitter FSM states
//               - EOF_BOTH_RAILS : rail mask toggled by the end-of-frame symbol
//               - rail_for_bit() : rail mask toggled by one data bit
//               - frame_period() : cycles from one accept to the earliest next
//                                  accept, for a given DATA_W and GAP
// Revision    : 1.0 - initial release
//==============================================================================
package ttt2_link_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SYM      = 2'd1,
      GAP_WAIT = 2'd2,
      EOF_WAIT = 2'd3
   } tx_state_t;

   // Bit 0 is rail 0 (line0), bit 1 is rail 1 (line1).
   localparam logic [1:0] EOF_BOTH_RAILS = 2'b11;

   // A '1' bit is signalled on rail 1, a '0' bit on rail 0.
   function automatic logic [1:0] rail_for_bit(input logic b);
      return b ? 2'b10 : 2'b01;
   endfunction

   // DATA_W data symbols plus one EOF symbol, each followed by GAP idle cycles.
   function automatic int frame_period(input int data_w, input int gap);
      return (data_w + 1) * (gap + 1);
   endfunction

endpackage : ttt2_link_pkg
`default_nettype wire

// File: rtl/ttt2_toggle_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : ttt2_toggle_tx_if
// Description : Valid/ready word handshake into the toggle transmitter.
//               in_valid : word offered          (master -> slave)
//               in_data  : payload, LSB sent first (master -> slave)
//               in_ready : slave accepts a word  (slave -> master)
// Revision    : 1.0 - initial release
//==============================================================================
interface ttt2_toggle_tx_if #(
   parameter int DATA_W = 8
) ();

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );

endinterface : ttt2_toggle_tx_if
`default_nettype wire

// File: rtl/ttt2_gap_timer.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : ttt2_gap_timer
// Description : Loadable down-counter that times the quiet period after every
//               rail symbol. Loading has priority over decrementing; the count
//               saturates at zero.
// Ports       : clk    - rising-edge clock
//               rst    - synchronous active-high reset (count -> 0)
//               i_load - load the count with GAP
//               i_dec  - decrement the count (ignored at zero)
//               o_zero - count is zero
//               o_last - count is one, i.e. the next decrement reaches zero
// Revision    : 1.0 - initial release
//==============================================================================
module ttt2_gap_timer #(
   parameter int GAP = 3
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_load,
   input  wire logic i_dec,
   output logic      o_zero,
   output logic      o_last
);

   generate
      if (GAP < 1) begin : g_gap_check
         $error("ttt2_gap_timer: GAP must be at least 1");
      end
   endgenerate

   localparam int                 CNT_W = (GAP < 1) ? 1 : $clog2(GAP + 1);
   localparam logic [CNT_W-1:0]   c_GAP = CNT_W'(GAP);
   localparam logic [CNT_W-1:0]   c_ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= c_GAP;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - c_ONE;
      end
   end

   assign o_zero = (r_count == '0);
   assign o_last = (r_count == c_ONE);

endmodule : ttt2_gap_timer
`default_nettype wire

// File: rtl/ttt2_toggle_tx.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : ttt2_toggle_tx
// Description : Two-phase dual-rail serial transmitter. Accepts a DATA_W word
//               over a valid/ready handshake and sends it LSB first as one
//               toggle per bit on the rail chosen by the bit value, followed by
//               an end-of-frame symbol that toggles both rails. Every symbol is
//               followed by GAP quiet cycles.
// Ports       : clk        - rising-edge clock
//               rst        - synchronous active-high reset
//               s_in       - word handshake (slave side: in_valid, in_data,
//                            in_ready; in_ready is registered)
//               line0      - rail 0, toggles once per '0' bit and on EOF
//               line1      - rail 1, toggles once per '1' bit and on EOF
//               busy       - frame in progress (registered)
//               frame_done - one-cycle pulse at the end of the frame period
// Revision    : 1.0 - initial release
//==============================================================================
module ttt2_toggle_tx
   import ttt2_link_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int GAP    = 3
) (
   input  wire logic             clk,
   input  wire logic             rst,
   ttt2_toggle_tx_if.slave       s_in,
   output logic                  line0,
   output logic                  line1,
   output logic                  busy,
   output logic                  frame_done
);

   generate
      if (DATA_W < 1) begin : g_data_w_check
         $error("ttt2_toggle_tx: DATA_W must be at least 1");
      end
   endgenerate

   localparam int               IDX_W      = $clog2(DATA_W + 1);
   localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(DATA_W);

   //---------------------------------------------------------------------------
   // State and datapath registers with their next-state values
   //---------------------------------------------------------------------------
   tx_state_t         r_state,  w_state_nxt;
   logic [DATA_W-1:0] r_shift,  w_shift_nxt;   // remaining bits, next bit at [0]
   logic [IDX_W-1:0]  r_idx,    w_idx_nxt;     // index of the next bit to send
   logic [1:0]        r_rails,  w_rails_nxt;   // {line1, line0}
   logic              r_ready,  w_ready_nxt;
   logic              r_busy,   w_busy_nxt;
   logic              r_done,   w_done_nxt;

   logic              w_gap_load;
   logic              w_gap_dec;
   logic              w_gap_zero;
   logic              w_gap_last;
   logic              w_accept;

   //---------------------------------------------------------------------------
   // Quiet-period timer
   //---------------------------------------------------------------------------
   ttt2_gap_timer #(
      .GAP    (GAP)
   ) u_gap_timer (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_gap_load),
      .i_dec  (w_gap_dec),
      .o_zero (w_gap_zero),
      .o_last (w_gap_last)
   );

   assign w_accept = s_in.in_valid && r_ready;

   //---------------------------------------------------------------------------
   // Register process
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_idx   <= '0;
         r_rails <= 2'b00;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_idx   <= w_idx_nxt;
         r_rails <= w_rails_nxt;
         r_ready <= w_ready_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state / control process
   //
   // Symbol spacing: a data symbol fires GAP+1 edges after the previous one
   // (GAP edges in GAP_WAIT counting down, then one SYM edge that toggles).
   // The EOF symbol toggles straight out of GAP_WAIT, so after the last data
   // bit GAP_WAIT lets the timer reach zero and then spends one more edge
   // there, keeping EOF on the same GAP+1 grid as the data symbols.
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_idx_nxt   = r_idx;
      w_rails_nxt = r_rails;
      w_ready_nxt = r_ready;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_gap_load  = 1'b0;
      w_gap_dec   = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               // Bit 0 goes out on the accept edge itself.
               w_rails_nxt = r_rails ^ rail_for_bit(s_in.in_data[0]);
               w_shift_nxt = s_in.in_data >> 1;
               w_idx_nxt   = c_IDX_ONE;
               w_ready_nxt = 1'b0;
               w_busy_nxt  = 1'b1;
               w_gap_load  = 1'b1;
               w_state_nxt = GAP_WAIT;
            end
         end

         GAP_WAIT: begin
            if (w_gap_zero) begin
               // Only reachable once every data bit has been sent.
               w_rails_nxt = r_rails ^ EOF_BOTH_RAILS;
               w_gap_load  = 1'b1;
               w_state_nxt = EOF_WAIT;
            end else begin
               w_gap_dec = 1'b1;
               if (w_gap_last && (r_idx < c_IDX_LAST)) begin
                  w_state_nxt = SYM;
               end
            end
         end

         SYM: begin
            w_rails_nxt = r_rails ^ rail_for_bit(r_shift[0]);
            w_shift_nxt = r_shift >> 1;
            w_idx_nxt   = r_idx + c_IDX_ONE;
            w_gap_load  = 1'b1;
            w_state_nxt = GAP_WAIT;
         end

         EOF_WAIT: begin
            w_gap_dec = 1'b1;
            if (w_gap_last) begin
               w_ready_nxt = 1'b1;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_state_nxt = IDLE;
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign s_in.in_ready = r_ready;
   assign line0         = r_rails[0];
   assign line1         = r_rails[1];
   assign busy          = r_busy;
   assign frame_done    = r_done;

endmodule : ttt2_toggle_tx
`default_nettype wire

// File: tb/tb_ttt2_toggle_tx.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : tb_ttt2_toggle_tx
// Description : Self-checking bench for ttt2_toggle_tx. Two instances run side
//               by side: A with the default DATA_W=8/GAP=3 and B with
//               DATA_W=1/GAP=1. On every accept the reference model pushes the
//               full list of expected rail events and the frame_done pulse,
//               each stamped with its edge number, into a per-instance queue;
//               the monitor pops an entry whenever the DUT shows a rail edge or
//               a frame_done pulse and compares edge and kind.
//               Event kinds: 0 = line0, 1 = line1, 2 = both rails, 3 = done.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_ttt2_toggle_tx;
   import ttt2_link_pkg::*;

   localparam int DW_A = 8;
   localparam int G_A  = 3;
   localparam int DW_B = 1;
   localparam int G_B  = 1;

   typedef struct {
      int at;
      int kind;
   } ev_t;
   typedef ev_t evq_t[$];

   typedef struct {
      int         next_ok;   // first edge at which an accept may happen
      logic [1:0] prev;      // rail levels seen after the previous edge
   } model_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstA, rstB;
   logic l0A, l1A, busyA, doneA;
   logic l0B, l1B, busyB, doneB;

   ttt2_toggle_tx_if #(.DATA_W(DW_A)) ifA ();
   ttt2_toggle_tx_if #(.DATA_W(DW_B)) ifB ();

   ttt2_toggle_tx #(.DATA_W(DW_A), .GAP(G_A)) u_dut_a (
      .clk        (clk),
      .rst        (rstA),
      .s_in       (ifA),
      .line0      (l0A),
      .line1      (l1A),
      .busy       (busyA),
      .frame_done (doneA)
   );

   ttt2_toggle_tx #(.DATA_W(DW_B), .GAP(G_B)) u_dut_b (
      .clk        (clk),
      .rst        (rstB),
      .s_in       (ifB),
      .line0      (l0B),
      .line1      (l1B),
      .busy       (busyB),
      .frame_done (doneB)
   );

   int     n     = 0;     // number of rising edges so far
   int     tests = 0;
   int     fails = 0;
   evq_t   qA, qB;
   model_t mA, mB;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, n);
      end
   endtask

   task automatic match_event(input string t, inout evq_t q, input int k);
      tests++;
      if (q.size() == 0) begin
         fails++;
         $display("FAIL %s event: got kind %0d at edge %0d, expected nothing", t, k, n);
      end else if (q[0].at != n || q[0].kind != k) begin
         fails++;
         $display("FAIL %s event: got kind %0d at edge %0d, expected kind %0d at edge %0d",
                  t, k, n, q[0].kind, q[0].at);
         if (q[0].at == n) void'(q.pop_front());
      end else begin
         void'(q.pop_front());
      end
   endtask

   // Reference model update plus checks for one instance after edge n.
   task automatic step(input int id, input int dw, input int g,
                       input logic r, input logic v, input logic [7:0] d,
                       input logic l0, input logic l1, input logic rdy,
                       input logic bsy, input logic dn);
      evq_t   q;
      model_t m;
      ev_t    e;
      int     k;
      logic   exp_rdy;
      string  t;
      t = (id == 0) ? "A" : "B";
      if (id == 0) begin q = qA; m = mA; end
      else         begin q = qB; m = mB; end

      if (r) begin
         // Reset wins: pending frame and its done pulse are discarded.
         q.delete();
         m.next_ok = 0;
         m.prev    = 2'b00;
         chk({t, " reset rails"}, int'({l1, l0}), 0);
         chk({t, " reset in_ready"}, int'(rdy), 1);
         chk({t, " reset busy"}, int'(bsy), 0);
         chk({t, " reset frame_done"}, int'(dn), 0);
      end else begin
         if (v && n >= m.next_ok) begin
            for (int i = 0; i < dw; i++) begin
               e.at   = n + i * (g + 1);
               e.kind = int'(d[i]);
               q.push_back(e);
            end
            e.at = n + dw * (g + 1);           e.kind = 2; q.push_back(e);
            e.at = n + (dw + 1) * (g + 1) - 1; e.kind = 3; q.push_back(e);
            m.next_ok = n + frame_period(dw, g);
         end
         while (q.size() > 0 && q[0].at < n) begin
            tests++;
            fails++;
            $display("FAIL %s missed event: kind %0d due at edge %0d, not seen by edge %0d",
                     t, q[0].kind, q[0].at, n);
            void'(q.pop_front());
         end
         if ({l1, l0} != m.prev) begin
            if (l0 != m.prev[0] && l1 != m.prev[1]) k = 2;
            else if (l1 != m.prev[1])               k = 1;
            else                                     k = 0;
            match_event(t, q, k);
         end
         m.prev = {l1, l0};
         if (dn) match_event(t, q, 3);
         exp_rdy = (n + 1 >= m.next_ok);
         chk({t, " in_ready"}, int'(rdy), int'(exp_rdy));
         chk({t, " busy"}, int'(bsy), int'(!exp_rdy));
      end

      if (id == 0) begin qA = q; mA = m; end
      else         begin qB = q; mB = m; end
   endtask

   // Monitor: bench-driven inputs are captured at the edge, DUT outputs 1ns later.
   initial begin : monitor
      logic       rA, vA, rB, vB;
      logic [7:0] dA, dB;
      mA.next_ok = 0; mA.prev = 2'b00;
      mB.next_ok = 0; mB.prev = 2'b00;
      forever begin
         @(posedge clk);
         n++;
         rA = rstA; vA = ifA.in_valid; dA = ifA.in_data;
         rB = rstB; vB = ifB.in_valid; dB = {7'b0, ifB.in_data};
         #1;
         step(0, DW_A, G_A, rA, vA, dA, l0A, l1A, ifA.in_ready, busyA, doneA);
         step(1, DW_B, G_B, rB, vB, dB, l0B, l1B, ifB.in_ready, busyB, doneB);
      end
   end

   //---------------------------------------------------------------------------
   // Drivers (called at a falling edge, return at a falling edge)
   //---------------------------------------------------------------------------
   task automatic sendA(input logic [7:0] d, input bit keep, output int acc);
      int k = 0;
      ifA.in_valid = 1'b1;
      ifA.in_data  = d;
      acc = -1;
      while (!ifA.in_ready && k < 200) begin @(negedge clk); k++; end
      if (!ifA.in_ready) begin
         tests++; fails++;
         $display("FAIL A accept timeout: in_ready=0, expected 1 within 200 cycles");
      end else begin
         acc = n + 1;
      end
      @(posedge clk);
      @(negedge clk);
      if (!keep) ifA.in_valid = 1'b0;
   endtask

   task automatic sendB(input logic d, input bit keep, output int acc);
      int k = 0;
      ifB.in_valid = 1'b1;
      ifB.in_data  = d;
      acc = -1;
      while (!ifB.in_ready && k < 200) begin @(negedge clk); k++; end
      if (!ifB.in_ready) begin
         tests++; fails++;
         $display("FAIL B accept timeout: in_ready=0, expected 1 within 200 cycles");
      end else begin
         acc = n + 1;
      end
      @(posedge clk);
      @(negedge clk);
      if (!keep) ifB.in_valid = 1'b0;
   endtask

   task automatic idleA(input bit scramble);
      int k = 0;
      while (!ifA.in_ready && k < 200) begin
         if (scramble) ifA.in_data = 8'($urandom);
         @(negedge clk);
         k++;
      end
      chk("A idle wait in_ready", int'(ifA.in_ready), 1);
   endtask

   task automatic driveA();
      int         e1, e2;
      logic [7:0] w;
      rstA = 1'b1; ifA.in_valid = 1'b1; ifA.in_data = 8'h3C;
      repeat (3) @(negedge clk);
      rstA = 1'b0; ifA.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      // Single frame 0xA5
      sendA(8'hA5, 1'b0, e1);
      idleA(1'b0);
      // Back-to-back 0x00 then 0xFF with in_valid held high
      sendA(8'h00, 1'b1, e1);
      sendA(8'hFF, 1'b0, e2);
      chk("A back-to-back accept spacing", e2 - e1, 36);
      idleA(1'b0);
      // in_data scrambled every cycle while busy
      w = 8'($urandom);
      sendA(w, 1'b0, e1);
      idleA(1'b1);
      // Reset at E+10
      w = 8'($urandom);
      sendA(w, 1'b0, e1);
      while (n + 1 < e1 + 10) @(negedge clk);
      rstA = 1'b1;
      @(negedge clk);
      rstA = 1'b0;
      sendA(8'h5A, 1'b0, e1);
      idleA(1'b0);
      // Random frames with random spacing
      for (int i = 0; i < 6; i++) begin
         w = 8'($urandom);
         repeat ($urandom_range(0, 4)) @(negedge clk);
         sendA(w, 1'($urandom_range(0, 1)), e1);
      end
      ifA.in_valid = 1'b0;
      idleA(1'b0);
   endtask

   task automatic driveB();
      int e1, e2;
      rstB = 1'b1; ifB.in_valid = 1'b1; ifB.in_data = 1'b1;
      repeat (2) @(negedge clk);
      rstB = 1'b0; ifB.in_valid = 1'b0;
      @(negedge clk);
      sendB(1'b1, 1'b1, e1);
      sendB(1'b0, 1'b0, e2);
      chk("B back-to-back period", e2 - e1, 4);
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         sendB(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e1);
      end
      ifB.in_valid = 1'b0;
   endtask

   initial begin : main
      rstA = 1'b1; rstB = 1'b1;
      ifA.in_valid = 1'b0; ifA.in_data = '0;
      ifB.in_valid = 1'b0; ifB.in_data = '0;
      fork
         driveA();
         driveB();
      join
      repeat (60) @(negedge clk);
      chk("A events left pending", qA.size(), 0);
      chk("B events left pending", qB.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_ttt2_toggle_tx
`default_nettype wire

// File: doc/ttt2_toggle_tx.md
# ttt2_toggle_tx

Two-phase (transition-signalled) dual-rail serial transmitter that drives the two toggle-encoded event lines consumed by the ttt2 controller benchmark's edge detectors. The receiving side flags an event by XOR-ing each line with its delayed copy. This block takes a parallel word through a valid/ready handshake and emits it LSB-first: one toggle per bit on the rail selected by the bit value, then an end-of-frame symbol that toggles both rails. It sits between the stimulus source and the ttt2 core in the power-aware synthesis benchmark harness.

## Interface
- DATA_W, 8, payload bits per frame (≥1)
- GAP, 3, idle cycles after every symbol (≥1; elaboration error otherwise)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  word offered
- in_data  input  DATA_W  payload, sent LSB first
- in_ready  output  1  block accepts a word (registered)
- line0  output  1  rail 0; toggles once per '0' bit
- line1  output  1  rail 1; toggles once per '1' bit
- busy  output  1  frame in progress (registered)
- frame_done  output  1  one-cycle pulse when the frame period ends

One clock; reset is synchronous and active-high.

## Operation
- Reset values: line0=0, line1=0, in_ready=1, busy=0, frame_done=0, state IDLE, counters 0.
- States: IDLE, SYM, GAP_WAIT, EOF_WAIT.
- IDLE: an accept occurs when in_valid and in_ready are both high at an edge. On that edge:
  - latch in_data into the shift register;
  - toggle the rail for bit 0;
  - clear in_ready; set busy;
  - load the gap counter with GAP; set the bit index to 1; go to GAP_WAIT.
- GAP_WAIT: decrement the gap counter. When it reaches 0:
  - if bit index < DATA_W, go to SYM;
  - otherwise toggle line0 and line1 together (EOF), reload GAP, go to EOF_WAIT.
- SYM: toggle the rail for the current bit, advance the index, reload GAP, go to GAP_WAIT. SYM lasts one cycle.
- EOF_WAIT: count down GAP−1 cycles. On the final edge, set in_ready=1, busy=0 and frame_done=1, then go to IDLE.
- Exactly one rail toggles per data symbol. Both rails toggle only on EOF. No other edges occur on the rails.
- in_valid is ignored while in_ready=0. in_data is sampled only on the accept edge.
- Reset during a frame aborts it at the next edge. Rails return to 0, and that return may itself look like a spurious edge; the receiver is reset together with this block. No frame_done is issued.
- Bit index width is $clog2(DATA_W+1). Gap counter width is $clog2(GAP+1). Counters never wrap in legal operation.

## Timing
- Let E be the accept edge.
- Data toggle for bit i is registered at edge E + i·(GAP+1), for i = 0..DATA_W−1.
- EOF toggle is registered at edge E + DATA_W·(GAP+1).
- in_ready rises and frame_done pulses at edge E + (DATA_W+1)·(GAP+1) − 1.
- The earliest next accept is E + (DATA_W+1)·(GAP+1). Back-to-back frames therefore have period (DATA_W+1)·(GAP+1) cycles; with defaults this is 36.
- Every rail edge is followed by at least GAP quiet cycles on both rails.
- If rst and in_valid are high on the same edge, reset wins and no accept occurs.

## Structure
- Shared package ttt2_link_pkg holds:
  - state enum tx_state_t {IDLE, SYM, GAP_WAIT, EOF_WAIT};
  - localparam EOF_BOTH_RAILS;
  - a function computing frame period from DATA_W and GAP, also used by the bench.
- One sub-module, ttt2_gap_timer: loadable down-counter with a zero flag, parameterised by GAP.
- Rails, shift register and FSM live in ttt2_toggle_tx.

## Test plan
- Reset check: assert rst for 3 cycles with in_valid=1. Required: line0=line1=0, in_ready=1, busy=0, no accept.
- Single frame, defaults, in_data=8'hA5 (bits LSB-first 1,0,1,0,0,1,0,1). Required:
  - line1 toggles at E+0, 8, 20, 28;
  - line0 toggles at E+4, 12, 16, 24;
  - both toggle at E+32;
  - final levels line0=1, line1=1;
  - frame_done at E+35.
- Back-to-back: in_valid held high with 8'h00 then 8'hFF. Required:
  - second accept at E+36;
  - frame 1: only line0 toggles, 8 times, then EOF;
  - frame 2: only line1 toggles, 8 times, then EOF.
- Data-change check: change in_data every cycle while busy. Required: the transmitted bits equal the value latched at E; in_ready stays 0 until E+35.
- Reset at E+10 mid-frame. Required: rails=0 and in_ready=1 after that edge; no frame_done; a new frame is accepted cleanly afterwards.
- Parameter sweep with DATA_W=1, GAP=1 and in_data=1. Required: line1 toggles at E, both rails toggle at E+2, frame_done at E+3, period 4.
